sliced_word_alu: RTL and testbench

- Parametrised multi-cycle successor to the 8-bit combinational ALU.
- Processes a WIDTH-bit operation one SLICE_WIDTH-bit slice per clock, least-significant slice first, with a registered carry/borrow between slices.
- Adds a start/busy/done handshake, registered results, and a full-word status flag.
- Sits between the operand/instruction registers and the result/flag registers of the wider datapath.

---
 rtl/sliced_word_alu.sv | 249 ++++++++++++++++++++++++
 tb/tb_sliced_word_alu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliced_word_alu.sv
`default_nettype none
// ============================================================================
// Module   : sliced_word_alu
// Purpose  : Multi-cycle ALU. A WIDTH-bit ADD/SUB/AND/OR is processed one
//            SLICE_WIDTH-bit slice per clock, least-significant slice first,
//            with a registered carry/borrow between slices. A start/busy/done
//            handshake frames each operation; results and flags are
//            registered and held until the next completion.
// Ports    : clk_i           - clock, all state changes on rising edge
//            rst_n_i         - synchronous active-low reset
//            start_i         - request a new operation (honoured in IDLE only)
//            a_i, b_i        - WIDTH-bit operands, sampled on accept
//            f_i             - 0 ADD, 1 SUB, 2 AND, 3 OR, sampled on accept
//            carry_borrow_i  - carry-in (ADD) / borrow-in (SUB), sampled on accept
//            busy_o          - high while slices are being processed
//            done_o          - one-cycle pulse, results valid
//            y_o             - WIDTH-bit result
//            carry_borrow_o  - final carry (ADD) / borrow (SUB), 0 for logic ops
//            status_flag_o   - 00 default, 01 zero, 10 overflow, 11 negative
// Revision : 1.0 - initial release
// ============================================================================
module sliced_word_alu #(
  parameter  int WIDTH       = 16,
  parameter  int SLICE_WIDTH = 4,
  localparam int NUM_SLICES  = WIDTH / SLICE_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       f_i,
  input  logic             carry_borrow_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_borrow_o,
  output logic [1:0]       status_flag_o
);

  // --------------------------------------------------------------------------
  // Elaboration-time sanity check on the slicing geometry
  // --------------------------------------------------------------------------
  generate
    if ((SLICE_WIDTH < 1) || ((WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_width
      $error("sliced_word_alu: WIDTH (%0d) must be a multiple of SLICE_WIDTH (%0d)",
             WIDTH, SLICE_WIDTH);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_SLICES - 1);

  localparam logic [1:0] c_F_ADD = 2'd0;
  localparam logic [1:0] c_F_SUB = 2'd1;
  localparam logic [1:0] c_F_AND = 2'd2;
  localparam logic [1:0] c_F_OR  = 2'd3;

  localparam logic [1:0] c_FLAG_DEFAULT = 2'b00;
  localparam logic [1:0] c_FLAG_ZERO    = 2'b01;
  localparam logic [1:0] c_FLAG_OVF     = 2'b10;
  localparam logic [1:0] c_FLAG_NEG     = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_a;       // shadow operand A, shifted right one slice per RUN edge
  logic [WIDTH-1:0] r_b;       // shadow operand B, shifted likewise
  logic [1:0]       r_f;
  logic             r_c;       // inter-slice carry / borrow
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_y;
  logic             r_cb;
  logic [1:0]       r_flag;

  // --------------------------------------------------------------------------
  // Slice datapath
  // --------------------------------------------------------------------------
  logic [SLICE_WIDTH-1:0] w_a_s;
  logic [SLICE_WIDTH-1:0] w_b_s;
  logic [SLICE_WIDTH:0]   w_sum;
  logic [SLICE_WIDTH:0]   w_diff;
  logic [SLICE_WIDTH-1:0] w_res_s;
  logic                   w_c_next;
  logic [WIDTH-1:0]       w_acc_next;  // full word including the slice of this edge
  logic [WIDTH-1:0]       w_a_shift;
  logic [WIDTH-1:0]       w_b_shift;
  logic                   w_last;
  logic                   w_y_zero;
  logic [1:0]             w_flag_next;

  // The current slice always sits in the low bits of the shadow registers.
  assign w_a_s = r_a[SLICE_WIDTH-1:0];
  assign w_b_s = r_b[SLICE_WIDTH-1:0];

  // One extra bit on top captures carry-out; for subtraction the extra bit
  // becomes 1 exactly when the slice result went negative, i.e. a borrow.
  assign w_sum  = {1'b0, w_a_s} + {1'b0, w_b_s} + {{SLICE_WIDTH{1'b0}}, r_c};
  assign w_diff = {1'b0, w_a_s} - {1'b0, w_b_s} - {{SLICE_WIDTH{1'b0}}, r_c};

  always_comb begin
    w_res_s  = '0;
    w_c_next = 1'b0;
    case (r_f)
      c_F_ADD: begin
        w_res_s  = w_sum[SLICE_WIDTH-1:0];
        w_c_next = w_sum[SLICE_WIDTH];
      end
      c_F_SUB: begin
        w_res_s  = w_diff[SLICE_WIDTH-1:0];
        w_c_next = w_diff[SLICE_WIDTH];
      end
      c_F_AND: begin
        w_res_s  = w_a_s & w_b_s;
        w_c_next = 1'b0;
      end
      c_F_OR: begin
        w_res_s  = w_a_s | w_b_s;
        w_c_next = 1'b0;
      end
      default: begin
        w_res_s  = '0;
        w_c_next = 1'b0;
      end
    endcase
  end

  assign w_last = (r_cnt == c_LAST);

  // Completed slices are shifted in from the top, so after the final slice
  // the first one has arrived at the bottom. The single-slice build needs no
  // accumulator or operand shifting at all.
  generate
    if (NUM_SLICES > 1) begin : g_multi
      logic [WIDTH-SLICE_WIDTH-1:0] r_acc;

      assign w_acc_next = {w_res_s, r_acc};
      assign w_a_shift  = {{SLICE_WIDTH{1'b0}}, r_a[WIDTH-1:SLICE_WIDTH]};
      assign w_b_shift  = {{SLICE_WIDTH{1'b0}}, r_b[WIDTH-1:SLICE_WIDTH]};

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          r_acc <= '0;
        end else if (r_state == S_RUN) begin
          r_acc <= w_acc_next[WIDTH-1:SLICE_WIDTH];
        end
      end
    end else begin : g_single
      assign w_acc_next = w_res_s;
      assign w_a_shift  = r_a;
      assign w_b_shift  = r_b;
    end
  endgenerate

  // Full-word status, evaluated on the word being completed this edge.
  assign w_y_zero = (w_acc_next == '0);

  always_comb begin
    w_flag_next = c_FLAG_DEFAULT;
    case (r_f)
      c_F_ADD: begin
        if (w_c_next)      w_flag_next = c_FLAG_OVF;
        else if (w_y_zero) w_flag_next = c_FLAG_ZERO;
      end
      c_F_SUB: begin
        if (w_c_next)      w_flag_next = c_FLAG_NEG;
        else if (w_y_zero) w_flag_next = c_FLAG_ZERO;
      end
      default: begin
        if (w_y_zero)      w_flag_next = c_FLAG_ZERO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= 2'd0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_cb    <= 1'b0;
      r_flag  <= 2'b00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_f     <= f_i;
            // Logic ops force the carry to 0 in the slice path, so seeding
            // unconditionally is harmless there.
            r_c     <= carry_borrow_i;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // start_i is deliberately not looked at here: no queuing.
          r_a   <= w_a_shift;
          r_b   <= w_b_shift;
          r_c   <= w_c_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_y     <= w_acc_next;
            r_cb    <= w_c_next;
            r_flag  <= w_flag_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign y_o            = r_y;
  assign carry_borrow_o = r_cb;
  assign status_flag_o  = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_sliced_word_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_sliced_word_alu
// Purpose  : Self-checking bench for sliced_word_alu. A 4-bit-slice instance
//            is driven through directed and random operations with a
//            scoreboard queue; 1-bit and 16-bit slice instances confirm the
//            same result at their own latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sliced_word_alu;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start0;
  logic          start_s;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    f;
  logic          cin;

  logic          busy0, done0, cb0;
  logic [W-1:0]  y0;
  logic [1:0]    flag0;
  logic          busy1, done1, cb1;
  logic [W-1:0]  y1;
  logic [1:0]    flag1;
  logic          busy16, done16, cb16;
  logic [W-1:0]  y16;
  logic [1:0]    flag16;

  always #5 clk = ~clk;

  sliced_word_alu #(.WIDTH(W), .SLICE_WIDTH(4)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start0),
    .a_i(a), .b_i(b), .f_i(f), .carry_borrow_i(cin),
    .busy_o(busy0), .done_o(done0), .y_o(y0),
    .carry_borrow_o(cb0), .status_flag_o(flag0)
  );

  sliced_word_alu #(.WIDTH(W), .SLICE_WIDTH(1)) u_dut_bs (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s),
    .a_i(a), .b_i(b), .f_i(f), .carry_borrow_i(cin),
    .busy_o(busy1), .done_o(done1), .y_o(y1),
    .carry_borrow_o(cb1), .status_flag_o(flag1)
  );

  sliced_word_alu #(.WIDTH(W), .SLICE_WIDTH(16)) u_dut_sc (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s),
    .a_i(a), .b_i(b), .f_i(f), .carry_borrow_i(cin),
    .busy_o(busy16), .done_o(done16), .y_o(y16),
    .carry_borrow_o(cb16), .status_flag_o(flag16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] y;
    logic         cb;
    logic [1:0]   flag;
  } res_t;

  res_t         q[$];
  logic [W-1:0] exp_last_y;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Whole-word reference model.
  function automatic res_t model(input logic [1:0] fo, input logic [W-1:0] ao,
                                 input logic [W-1:0] bo, input logic co);
    res_t        r;
    logic [W:0]  t;
    r = '0;
    case (fo)
      2'd0: begin
        t    = {1'b0, ao} + {1'b0, bo} + (W+1)'(co);
        r.y  = t[W-1:0];
        r.cb = t[W];
        r.flag = r.cb ? 2'b10 : ((r.y == '0) ? 2'b01 : 2'b00);
      end
      2'd1: begin
        t    = {1'b0, ao} - {1'b0, bo} - (W+1)'(co);
        r.y  = t[W-1:0];
        r.cb = t[W];
        r.flag = r.cb ? 2'b11 : ((r.y == '0) ? 2'b01 : 2'b00);
      end
      2'd2: begin
        r.y  = ao & bo;
        r.cb = 1'b0;
        r.flag = (r.y == '0) ? 2'b01 : 2'b00;
      end
      default: begin
        r.y  = ao | bo;
        r.cb = 1'b0;
        r.flag = (r.y == '0) ? 2'b01 : 2'b00;
      end
    endcase
    return r;
  endfunction

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done0 === 1'b1) begin
      if (q.size() == 0) begin
        check_eq("spurious_done_qsize", 32'(q.size()), 32'd1);
      end else begin
        res_t e;
        e = q.pop_front();
        check_eq("y",    32'(y0),    32'(e.y));
        check_eq("cb",   32'(cb0),   32'(e.cb));
        check_eq("flag", 32'(flag0), 32'(e.flag));
      end
    end
  end

  // Issue one operation from a negedge; returns at the negedge of the
  // done cycle. Optionally pulses a competing ADD start during RUN.
  task automatic run_op(input logic [1:0] fo, input logic [W-1:0] ao,
                        input logic [W-1:0] bo, input logic co, input bit inject);
    int cyc    = 0;
    int busy_n = 0;
    bit got    = 1'b0;
    f = fo; a = ao; b = bo; cin = co; start0 = 1'b1;
    q.push_back(model(fo, ao, bo, co));
    @(posedge clk);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      start0 = inject && (cyc == 1);
      a   = W'($urandom);
      b   = W'($urandom);
      f   = inject ? 2'd0 : 2'($urandom);
      cin = 1'($urandom);
      if (done0 === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy0 === 1'b1) busy_n++;
        check_eq("y_hold_during_run", 32'(y0), 32'(exp_last_y));
      end
    end
    check_eq("done_seen",   32'(got), 32'd1);
    check_eq("latency",     32'(cyc), 32'd5);
    check_eq("busy_cycles", 32'(busy_n), 32'd4);
    exp_last_y = model(fo, ao, bo, co).y;
  endtask

  task automatic expect_done_low;
    @(negedge clk);
    check_eq("done_width", 32'(done0), 32'd0);
  endtask

  task automatic run_sweep;
    int  cyc = 0;
    bit  got1 = 1'b0, got16 = 1'b0;
    int  lat1 = 0, lat16 = 0;
    f = 2'd0; a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start_s = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40 && !(got1 && got16); i++) begin
      @(negedge clk);
      cyc++;
      start_s = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (done1 === 1'b1 && !got1) begin
        got1 = 1'b1; lat1 = cyc;
        check_eq("sw1_y",    32'(y1),    32'h0000);
        check_eq("sw1_cb",   32'(cb1),   32'd1);
        check_eq("sw1_flag", 32'(flag1), 32'd2);
      end
      if (done16 === 1'b1 && !got16) begin
        got16 = 1'b1; lat16 = cyc;
        check_eq("sw16_y",    32'(y16),    32'h0000);
        check_eq("sw16_cb",   32'(cb16),   32'd1);
        check_eq("sw16_flag", 32'(flag16), 32'd2);
      end
    end
    check_eq("sw1_done_seen",  32'(got1),  32'd1);
    check_eq("sw16_done_seen", 32'(got16), 32'd1);
    check_eq("sw1_latency",    32'(lat1),  32'd17);
    check_eq("sw16_latency",   32'(lat16), 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start_s = 1'b0;
    a = '0; b = '0; f = 2'd0; cin = 1'b0;
    exp_last_y = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_done", 32'(done0), 32'd0);
    check_eq("rst_y",    32'(y0),    32'd0);
    check_eq("rst_cb",   32'(cb0),   32'd0);
    check_eq("rst_flag", 32'(flag0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD overflow
    run_op(2'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    expect_done_low();

    // SUB negative, then back-to-back SUB to zero
    run_op(2'd1, 16'h0003, 16'h0005, 1'b0, 1'b0);
    run_op(2'd1, 16'h1234, 16'h1234, 1'b0, 1'b0);
    expect_done_low();

    // ADD with carry-in, then AND with ignored carry-in
    run_op(2'd0, 16'h00FF, 16'h0001, 1'b1, 1'b0);
    run_op(2'd2, 16'hF0F0, 16'h0F0F, 1'b1, 1'b0);
    expect_done_low();

    // OR with a competing start during RUN; no second done may follow
    run_op(2'd3, 16'h1200, 16'h0034, 1'b0, 1'b1);
    repeat (8) @(negedge clk);

    // Reset mid-RUN
    f = 2'd0; a = 16'h0001; b = 16'h0001; cin = 1'b0; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy0), 32'd0);
    check_eq("midrst_done", 32'(done0), 32'd0);
    check_eq("midrst_y",    32'(y0),    32'd0);
    check_eq("midrst_cb",   32'(cb0),   32'd0);
    check_eq("midrst_flag", 32'(flag0), 32'd0);
    rst_n = 1'b1;
    exp_last_y = '0;
    repeat (8) @(negedge clk);
    run_op(2'd0, 16'h0002, 16'h0003, 1'b0, 1'b0);
    expect_done_low();

    // Other slice widths
    run_sweep();
    repeat (20) @(negedge clk);

    // Random back-to-back traffic
    for (int k = 0; k < 16; k++) begin
      run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    expect_done_low();

    repeat (10) @(negedge clk);
    check_eq("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
